// File: rtl/rom_access_arbiter.sv
// ============================================================================
// rom_access_arbiter : round-robin sharing of one ROM read port by two ports
// Rev 1.0
// ============================================================================
`default_nettype none

module rom_access_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk_ARB,
  input  logic              rst_ARB,
  input  logic              req0_ARB,
  input  logic [ADDR_W-1:0] addr0_ARB,
  output logic              gnt0_ARB,
  output logic              vld0_ARB,
  input  logic              req1_ARB,
  input  logic [ADDR_W-1:0] addr1_ARB,
  output logic              gnt1_ARB,
  output logic              vld1_ARB,
  output logic [DATA_W-1:0] rdata_ARB,
  output logic [ADDR_W-1:0] addr_ROM,
  input  logic [DATA_W-1:0] data_ROM,
  output logic              busy_ARB
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_rr;
  logic              r_port;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_vld0;
  logic              r_vld1;
  logic              r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;

  logic              w_any_req;
  logic              w_win_port;

  // r_rr names the preferred port: the one not served most recently
  assign w_any_req  = req0_ARB | req1_ARB;
  assign w_win_port = (req0_ARB & req1_ARB) ? r_rr : req1_ARB;

  always_ff @(posedge clk_ARB or posedge rst_ARB) begin
    if (rst_ARB) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_port  <= 1'b0;
      r_cnt   <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_any_req) begin
            r_gnt0  <= ~w_win_port;
            r_gnt1  <= w_win_port;
            r_addr  <= w_win_port ? addr1_ARB : addr0_ARB;
            r_port  <= w_win_port;
            r_rr    <= ~w_win_port;
            r_cnt   <= CNT_W'(ROM_LAT);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          // Address went out in the grant cycle; data is on the bus once the count is spent
          if (r_cnt == '0) begin
            r_rdata <= data_ROM;
            r_vld0  <= ~r_port;
            r_vld1  <= r_port;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0_ARB  = r_gnt0;
  assign gnt1_ARB  = r_gnt1;
  assign vld0_ARB  = r_vld0;
  assign vld1_ARB  = r_vld1;
  assign busy_ARB  = r_busy;
  assign addr_ROM  = r_addr;
  assign rdata_ARB = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_rom_access_arbiter.sv
// ============================================================================
// tb_rom_access_arbiter : scoreboard bench, three DUTs with ROM_LAT 1, 3 and 4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rom_access_arbiter;

  localparam int N_DUT = 3;

  typedef struct {
    int inst;
    int port;
    int cyc;
    int val;
  } txn_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  logic       rst      [N_DUT];
  logic       req0     [N_DUT];
  logic       req1     [N_DUT];
  logic [7:0] addr0    [N_DUT];
  logic [7:0] addr1    [N_DUT];
  logic       gnt0     [N_DUT];
  logic       gnt1     [N_DUT];
  logic       vld0     [N_DUT];
  logic       vld1     [N_DUT];
  logic       busy     [N_DUT];
  logic [7:0] rdata    [N_DUT];
  logic [7:0] addr_rom [N_DUT];
  logic [7:0] data_rom [N_DUT];
  logic [7:0] rom      [16];

  txn_t gq[$];
  txn_t vq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [7:0] pipe [4];

    // ROM model: data for addr_ROM appears LAT cycles after it is presented
    always @(posedge clk) begin
      pipe[0] <= rom[addr_rom[g][3:0]];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign data_rom[g] = pipe[LAT-1];

    rom_access_arbiter #(.ADDR_W(8), .DATA_W(8), .ROM_LAT(LAT)) u_dut (
      .clk_ARB   (clk),
      .rst_ARB   (rst[g]),
      .req0_ARB  (req0[g]),
      .addr0_ARB (addr0[g]),
      .gnt0_ARB  (gnt0[g]),
      .vld0_ARB  (vld0[g]),
      .req1_ARB  (req1[g]),
      .addr1_ARB (addr1[g]),
      .gnt1_ARB  (gnt1[g]),
      .vld1_ARB  (vld1[g]),
      .rdata_ARB (rdata[g]),
      .addr_ROM  (addr_rom[g]),
      .data_ROM  (data_rom[g]),
      .busy_ARB  (busy[g])
    );
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse(input int i);
    rst[i] = 1'b1;
    tick();
    tick();
    rst[i] = 1'b0;
  endtask

  task automatic push(input int i, input int p, input int gcyc, input int vcyc, input int a);
    txn_t t;
    t.inst = i; t.port = p; t.cyc = gcyc; t.val = a;
    gq.push_back(t);
    if (vcyc >= 0) begin
      t.cyc = vcyc; t.val = rom[a];
      vq.push_back(t);
    end
  endtask

  // Monitor: every grant and valid pulse must match the head of its queue
  always @(negedge clk) begin
    txn_t e;
    for (int i = 0; i < N_DUT; i++) begin
      if (gnt0[i] || gnt1[i]) begin
        chk("gnt_excl", int'(gnt0[i] & gnt1[i]), 0);
        chk("gnt_busy", int'(busy[i]), 1);
        chk("gnt_expected", int'(gq.size() > 0), 1);
        if (gq.size() > 0) begin
          e = gq.pop_front();
          chk("gnt_inst", i, e.inst);
          chk("gnt_port", int'(gnt1[i]), e.port);
          chk("gnt_cyc", cyc, e.cyc);
          chk("gnt_addr", int'(addr_rom[i]), e.val);
        end
      end
      if (vld0[i] || vld1[i]) begin
        chk("vld_excl", int'(vld0[i] & vld1[i]), 0);
        chk("vld_busy", int'(busy[i]), 1);
        chk("vld_expected", int'(vq.size() > 0), 1);
        if (vq.size() > 0) begin
          e = vq.pop_front();
          chk("vld_inst", i, e.inst);
          chk("vld_port", int'(vld1[i]), e.port);
          chk("vld_cyc", cyc, e.cyc);
          chk("vld_data", int'(rdata[i]), e.val);
        end
      end
    end
  end

  initial begin
    int n;
    for (int a = 0; a < 16; a++) rom[a] = 8'(8'h30 + a * 7);
    rom[1] = 8'h11;
    rom[2] = 8'h22;
    rom[3] = 8'hA5;
    for (int i = 0; i < N_DUT; i++) begin
      rst[i] = 1'b1; req0[i] = 1'b0; req1[i] = 1'b0; addr0[i] = '0; addr1[i] = '0;
    end

    // Reset with random request traffic
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N_DUT; i++) begin
        req0[i]  = 1'($urandom_range(0, 1));
        req1[i]  = 1'($urandom_range(0, 1));
        addr0[i] = 8'($urandom_range(0, 15));
        addr1[i] = 8'($urandom_range(0, 15));
      end
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++)
        chk("reset_outs", int'({gnt0[i], gnt1[i], vld0[i], vld1[i], busy[i], addr_rom[i], rdata[i]}), 0);
      tick();
    end
    for (int i = 0; i < N_DUT; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; rst[i] = 1'b0;
    end
    tick();

    // Single read, ROM_LAT=1
    tick();
    n = cyc;
    req0[0] = 1'b1; addr0[0] = 8'h03;
    push(0, 0, n + 1, n + 3, 3);
    @(negedge clk); chk("busy_single", int'(busy[0]), 0);
    tick();
    req0[0] = 1'b0;
    @(negedge clk); chk("busy_single", int'(busy[0]), 1);
    @(negedge clk); chk("busy_single", int'(busy[0]), 1);
    @(negedge clk); chk("busy_single", int'(busy[0]), 1);
    @(negedge clk); chk("busy_single", int'(busy[0]), 0);
    repeat (3) tick();

    // Simultaneous requests straight after reset: port 0 first
    rst_pulse(0);
    tick();
    n = cyc;
    req0[0] = 1'b1; addr0[0] = 8'h01;
    req1[0] = 1'b1; addr1[0] = 8'h02;
    push(0, 0, n + 1, n + 3, 1);
    push(0, 1, n + 4, n + 6, 2);
    tick();
    req0[0] = 1'b0;
    repeat (3) tick();
    req1[0] = 1'b0;
    repeat (5) tick();

    // Fairness: both requests held for eight back-to-back transactions
    n = cyc;
    req0[0] = 1'b1; addr0[0] = 8'h04;
    req1[0] = 1'b1; addr1[0] = 8'h05;
    for (int k = 0; k < 8; k++)
      push(0, k % 2, n + 1 + 3 * k, n + 3 + 3 * k, (k % 2 == 1) ? 5 : 4);
    repeat (22) tick();
    req0[0] = 1'b0; req1[0] = 1'b0;
    repeat (6) tick();

    // Reset in WAIT, ROM_LAT=3: the in-flight read is dropped
    n = cyc;
    req1[1] = 1'b1; addr1[1] = 8'h06;
    push(1, 1, n + 1, -1, 6);
    tick();
    req1[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    @(negedge clk); chk("busy_in_reset", int'(busy[1]), 0);
    tick();
    rst[1] = 1'b0;
    repeat (6) tick();
    n = cyc;
    req0[1] = 1'b1; addr0[1] = 8'h07;
    req1[1] = 1'b1; addr1[1] = 8'h08;
    push(1, 0, n + 1, n + 5, 7);
    push(1, 1, n + 6, n + 10, 8);
    tick();
    req0[1] = 1'b0;
    repeat (5) tick();
    req1[1] = 1'b0;
    repeat (7) tick();

    // ROM_LAT=4 latency, with a port 0 request withdrawn while busy
    n = cyc;
    req1[2] = 1'b1; addr1[2] = 8'h09;
    push(2, 1, n + 1, n + 6, 9);
    tick();
    req1[2] = 1'b0;
    tick();
    req0[2] = 1'b1; addr0[2] = 8'h0A;
    repeat (2) tick();
    req0[2] = 1'b0;
    repeat (8) tick();

    chk("gnt_queue_drained", gq.size(), 0);
    chk("vld_queue_drained", vq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
